// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcodes, instruction field positions and FSM states for alu_issue_ctrl
package alu_issue_pkg;
  localparam logic [3:0] ALU_ADD     = 4'h0;
  localparam logic [3:0] ALU_SUB     = 4'h1;
  localparam logic [3:0] ALU_AND     = 4'h2;
  localparam logic [3:0] ALU_OR      = 4'h3;
  localparam logic [3:0] ALU_SLL     = 4'h4;
  localparam logic [3:0] ALU_SRL     = 4'h5;
  localparam logic [3:0] ALU_SRA     = 4'h6;
  localparam logic [3:0] ALU_XOR     = 4'h7;
  localparam logic [3:0] ALU_NOR     = 4'h8;
  localparam logic [3:0] ALU_NAND    = 4'h9;
  localparam logic [3:0] ALU_XNOR    = 4'hA;
  localparam logic [3:0] ALU_SLT     = 4'hB;
  localparam logic [3:0] ALU_SLTU    = 4'hC;
  localparam logic [3:0] ALU_MOV     = 4'hD;
  localparam logic [3:0] ALU_MVN     = 4'hE;
  localparam logic [3:0] ALU_ILLEGAL = 4'hF;
  localparam int OP_LSB      = 28;
  localparam int RD_LSB      = 24;
  localparam int RS1_LSB     = 20;
  localparam int RS2_LSB     = 16;
  localparam int IMM_SEL_BIT = 15;
  localparam int SHAMT_LSB   = 8;
  localparam int IMM8_LSB    = 0;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: NREG x 32 register file, two async read ports with write-first bypass, one sync write port
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int NREG = 8,
  parameter int RA_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [31:0]     wdata,
  input  logic [RA_W-1:0] raddr1,
  input  logic [RA_W-1:0] raddr2,
  output logic [31:0]     rdata1,
  output logic [31:0]     rdata2
);
  logic [31:0] r_mem [NREG];
  // storage: cleared on reset, single write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end
  // a write landing this cycle is visible to a read of the same register
  always_comb begin
    rdata1 = (we && waddr == raddr1) ? wdata : r_mem[raddr1];
    rdata2 = (we && waddr == raddr2) ? wdata : r_mem[raddr2];
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller for a combinational ALU; optional ALU_ILLEGAL_OP_CHECK_EN traps op 4'hF
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int NREG = 8,
  parameter int RA_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic            host_wr_en,
  input  logic [RA_W-1:0] host_wr_addr,
  input  logic [31:0]     host_wr_data,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [3:0]      alu_op,
  output logic [4:0]      alu_shift,
  input  logic [31:0]     alu_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic [RA_W-1:0] rsp_rd,
  output logic            rsp_err
);
  state_t          r_state;
  logic [RA_W-1:0] r_rd;
  logic            w_we;
  logic [RA_W-1:0] w_waddr;
  logic [31:0]     w_wdata;
  logic [31:0]     w_rd1;
  logic [31:0]     w_rd2;
  logic            w_illegal;
  logic            w_unused;
  assign instr_ready = r_state == S_IDLE;
  assign w_unused = ^instr;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  assign w_illegal = alu_op == ALU_ILLEGAL;
`else
  assign w_illegal = 1'b0;
`endif
  // host owns the write port in IDLE, writeback owns it in EXEC
  always_comb begin
    w_we    = (r_state == S_IDLE && host_wr_en) || (r_state == S_EXEC && !w_illegal);
    w_waddr = r_state == S_IDLE ? host_wr_addr : r_rd;
    w_wdata = r_state == S_IDLE ? host_wr_data : alu_out;
  end
  alu_issue_regfile #(.NREG(NREG), .RA_W(RA_W)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (w_we),
    .waddr  (w_waddr),
    .wdata  (w_wdata),
    .raddr1 (instr[RS1_LSB +: RA_W]),
    .raddr2 (instr[RS2_LSB +: RA_W]),
    .rdata1 (w_rd1),
    .rdata2 (w_rd2)
  );
  // issue FSM: latch operands on accept, capture result after one EXEC cycle, hold until consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rd      <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_shift <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (instr_valid) begin
          alu_a     <= w_rd1;
          alu_b     <= instr[IMM_SEL_BIT] ? {24'b0, instr[IMM8_LSB +: 8]} : w_rd2;
          alu_op    <= instr[OP_LSB +: 4];
          alu_shift <= instr[SHAMT_LSB +: 5];
          r_rd      <= instr[RD_LSB +: RA_W];
          rsp_err   <= 1'b0;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          rsp_data  <= w_illegal ? '0 : alu_out;
          rsp_rd    <= r_rd;
          rsp_err   <= w_illegal;
          rsp_valid <= 1'b1;
          r_state   <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against a register-array model
module tb_alu_issue_ctrl;
  logic        clk = 0, reset = 1, instr_valid = 0, host_wr_en = 0, rsp_ready = 1;
  logic [31:0] instr = 0, host_wr_data = 0, alu_out;
  logic [2:0]  host_wr_addr = 0;
  logic        instr_ready, rsp_valid, rsp_err;
  logic [31:0] alu_a, alu_b, rsp_data;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shift;
  logic [2:0]  rsp_rd;
  int          n_checks = 0, n_fail = 0;
  logic [31:0] m [8];

  alu_issue_ctrl #(.NREG(8), .RA_W(3)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shift(alu_shift), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic [4:0] sh);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a << sh;
      4'h5: return a >> sh;
      4'h6: return $unsigned($signed(a) >>> sh);
      4'h7: return a ^ b;
      4'h8: return ~(a | b);
      4'h9: return ~(a & b);
      4'hA: return ~(a ^ b);
      4'hB: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC: return (a < b) ? 32'd1 : 32'd0;
      4'hD: return b;
      4'hE: return ~b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_out = alu_ref(alu_a, alu_b, alu_op, alu_shift);

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic isel, input logic [4:0] sh, input logic [7:0] imm);
    return {op, rd, rs1, rs2, isel, 2'b00, sh, imm};
  endfunction

  function automatic bit is_illegal(input logic [3:0] op);
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    return op == 4'hF;
`else
    return 1'b0;
`endif
  endfunction

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    host_wr_en = 1; host_wr_addr = a; host_wr_data = d;
    @(negedge clk);
    host_wr_en = 0;
    m[a] = d;
  endtask

  task automatic run_instr(input logic [31:0] ins, input bit hw, input logic [2:0] hwa, input logic [31:0] hwd, input int stall,
                           output logic [31:0] ea, output logic [31:0] eb, output logic [3:0] eop, output logic [4:0] esh,
                           output logic v2, output logic [31:0] d, output logic [2:0] rrd, output logic e, output logic rdy3);
    instr = ins; instr_valid = 1; rsp_ready = (stall == 0);
    host_wr_en = hw; host_wr_addr = hwa; host_wr_data = hwd;
    @(negedge clk);
    instr_valid = 0; host_wr_en = 0;
    ea = alu_a; eb = alu_b; eop = alu_op; esh = alu_shift;
    @(negedge clk);
    v2 = rsp_valid; d = rsp_data; rrd = rsp_rd; e = rsp_err;
    repeat (stall) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rdy3 = instr_ready & ~rsp_valid;
  endtask

  task automatic read_reg(input logic [2:0] r, output logic [31:0] v, output logic e);
    logic [31:0] ea, eb; logic [3:0] eop; logic [4:0] esh; logic v2, rdy3; logic [2:0] rrd;
    run_instr(mk(4'h3, {1'b0, r}, {1'b0, r}, 4'h0, 1'b1, 5'd0, 8'h00), 0, 0, 0, 0, ea, eb, eop, esh, v2, v, rrd, e, rdy3);
  endtask

  task automatic test_reset;
    logic [31:0] v; logic e;
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 8; i++) m[i] = 0;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_instr_ready got %0b exp 1", instr_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    n_checks++; if ({alu_a, alu_b, alu_op, alu_shift} !== 73'd0) begin n_fail++; $display("FAIL reset_alu got a=%h b=%h op=%h sh=%h exp 0", alu_a, alu_b, alu_op, alu_shift); end
    n_checks++; if ({rsp_data, rsp_rd, rsp_err} !== 36'd0) begin n_fail++; $display("FAIL reset_rsp got d=%h rd=%0d err=%0b exp 0", rsp_data, rsp_rd, rsp_err); end
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_hold got %0b exp 1", instr_ready); end
    read_reg(5, v, e);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_reg5 got %h exp 0", v); end
  endtask

  task automatic test_add;
    logic [31:0] ea, eb, d, v; logic [3:0] eop; logic [4:0] esh; logic v2, e, rdy3; logic [2:0] rrd;
    host_write(1, 32'h5);
    host_write(2, 32'h3);
    run_instr(mk(4'h0, 4'd3, 4'd1, 4'd2, 1'b0, 5'd0, 8'h0), 0, 0, 0, 0, ea, eb, eop, esh, v2, d, rrd, e, rdy3);
    n_checks++; if (ea !== 32'h5 || eb !== 32'h3 || eop !== 4'h0) begin n_fail++; $display("FAIL add_issue got a=%h b=%h op=%h exp 5 3 0", ea, eb, eop); end
    n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL add_valid_t2 got %0b exp 1", v2); end
    n_checks++; if (d !== 32'h8 || rrd !== 3'd3) begin n_fail++; $display("FAIL add_rsp got d=%h rd=%0d exp 8 3", d, rrd); end
    n_checks++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL add_ready_t3 got %0b exp 1", rdy3); end
    m[3] = 32'h8;
    read_reg(3, v, e);
    n_checks++; if (v !== 32'h8) begin n_fail++; $display("FAIL add_r3 got %h exp 8", v); end
  endtask

  task automatic test_sub_shift;
    logic [31:0] ea, eb, d; logic [3:0] eop; logic [4:0] esh; logic v2, e, rdy3; logic [2:0] rrd;
    host_write(1, 32'h3);
    run_instr(mk(4'h1, 4'd4, 4'd1, 4'd0, 1'b1, 5'd0, 8'h05), 0, 0, 0, 0, ea, eb, eop, esh, v2, d, rrd, e, rdy3);
    n_checks++; if (eb !== 32'h5) begin n_fail++; $display("FAIL sub_imm_b got %h exp 5", eb); end
    n_checks++; if (d !== 32'hFFFF_FFFE || rrd !== 3'd4) begin n_fail++; $display("FAIL sub_rsp got d=%h rd=%0d exp fffffffe 4", d, rrd); end
    m[4] = 32'hFFFF_FFFE;
    run_instr(mk(4'h4, 4'd7, 4'd1, 4'd0, 1'b0, 5'd4, 8'h0), 0, 0, 0, 0, ea, eb, eop, esh, v2, d, rrd, e, rdy3);
    n_checks++; if (esh !== 5'd4 || eop !== 4'h4) begin n_fail++; $display("FAIL sll_issue got sh=%0d op=%h exp 4 4", esh, eop); end
    n_checks++; if (d !== 32'h30) begin n_fail++; $display("FAIL sll_rsp got %h exp 30", d); end
    m[7] = 32'h30;
  endtask

  task automatic test_stall;
    logic [31:0] v; logic e;
    host_write(0, 32'h77);
    instr = mk(4'h0, 4'd2, 4'd0, 4'd0, 1'b1, 5'd0, 8'h01); instr_valid = 1; rsp_ready = 0;
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h78) begin n_fail++; $display("FAIL stall_first got v=%0b d=%h exp 1 78", rsp_valid, rsp_data); end
    for (int i = 0; i < 5; i++) begin
      host_wr_en = 1; host_wr_addr = 0; host_wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h78 || rsp_rd !== 3'd2 || instr_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d] got v=%0b d=%h rd=%0d rdy=%0b exp 1 78 2 0", i, rsp_valid, rsp_data, rsp_rd, instr_ready);
      end
    end
    host_wr_en = 0; rsp_ready = 1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got v=%0b rdy=%0b exp 0 1", rsp_valid, instr_ready); end
    m[2] = 32'h78;
    read_reg(0, v, e);
    n_checks++; if (v !== 32'h77) begin n_fail++; $display("FAIL stall_r0 got %h exp 77", v); end
  endtask

  task automatic test_bypass;
    logic [31:0] ea, eb, d, v; logic [3:0] eop; logic [4:0] esh; logic v2, e, rdy3; logic [2:0] rrd;
    host_write(1, 32'h55);
    run_instr(mk(4'h3, 4'd5, 4'd1, 4'd0, 1'b1, 5'd0, 8'h00), 1, 3'd1, 32'hAA, 0, ea, eb, eop, esh, v2, d, rrd, e, rdy3);
    n_checks++; if (ea !== 32'hAA || d !== 32'hAA) begin n_fail++; $display("FAIL bypass got a=%h d=%h exp aa aa", ea, d); end
    m[1] = 32'hAA; m[5] = 32'hAA;
    read_reg(1, v, e);
    n_checks++; if (v !== 32'hAA) begin n_fail++; $display("FAIL bypass_r1 got %h exp aa", v); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v; logic e;
    host_write(4, 32'h99);
    instr = mk(4'h0, 4'd6, 4'd4, 4'd4, 1'b0, 5'd0, 8'h0); instr_valid = 1; rsp_ready = 1;
    @(negedge clk);
    instr_valid = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    n_checks++; if (rsp_valid !== 1'b0 || instr_ready !== 1'b1 || alu_a !== 32'd0) begin n_fail++; $display("FAIL rstmid_state got v=%0b rdy=%0b a=%h exp 0 1 0", rsp_valid, instr_ready, alu_a); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_norsp[%0d] got %0b exp 0", i, rsp_valid); end
    end
    for (int i = 0; i < 8; i++) m[i] = 0;
    for (int i = 0; i < 8; i++) begin
      read_reg(i[2:0], v, e);
      n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rstmid_r%0d got %h exp 0", i, v); end
    end
  endtask

  task automatic test_illegal;
    logic [31:0] ea, eb, d, v; logic [3:0] eop; logic [4:0] esh; logic v2, e, rdy3; logic [2:0] rrd;
    host_write(6, 32'h1234);
    run_instr(mk(4'hF, 4'd6, 4'd6, 4'd6, 1'b0, 5'd0, 8'h0), 0, 0, 0, 0, ea, eb, eop, esh, v2, d, rrd, e, rdy3);
    if (!is_illegal(4'hF)) m[6] = 0;
    n_checks++; if (e !== is_illegal(4'hF) || d !== 32'd0 || v2 !== 1'b1) begin n_fail++; $display("FAIL illegal_rsp got err=%0b d=%h v=%0b exp %0b 0 1", e, d, v2, is_illegal(4'hF)); end
    read_reg(6, v, e);
    n_checks++; if (v !== m[6]) begin n_fail++; $display("FAIL illegal_r6 got %h exp %h", v, m[6]); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL illegal_err_clear got %0b exp 0", e); end
  endtask

  task automatic test_random;
    logic [31:0] ins, hwd, a, b, res, exp_d, ea, eb, d, v; logic [3:0] eop; logic [4:0] esh; logic v2, e, rdy3, ill, hw; logic [2:0] rrd, hwa;
    for (int n = 0; n < 60; n++) begin
      ins = $urandom; hw = 1'($urandom_range(0, 1)); hwa = 3'($urandom); hwd = $urandom;
      run_instr(ins, hw, hwa, hwd, $urandom_range(0, 2), ea, eb, eop, esh, v2, d, rrd, e, rdy3);
      if (hw) m[hwa] = hwd;
      a = m[ins[22:20]];
      b = ins[15] ? {24'b0, ins[7:0]} : m[ins[18:16]];
      res = alu_ref(a, b, ins[31:28], ins[12:8]);
      ill = is_illegal(ins[31:28]);
      exp_d = ill ? 32'd0 : res;
      if (!ill) m[ins[26:24]] = res;
      n_checks++;
      if (ea !== a || eb !== b || eop !== ins[31:28] || esh !== ins[12:8]) begin
        n_fail++; $display("FAIL rand_issue[%0d] got a=%h b=%h op=%h sh=%0d exp %h %h %h %0d", n, ea, eb, eop, esh, a, b, ins[31:28], ins[12:8]);
      end
      n_checks++;
      if (v2 !== 1'b1 || d !== exp_d || rrd !== ins[26:24] || e !== ill || rdy3 !== 1'b1) begin
        n_fail++; $display("FAIL rand_rsp[%0d] got v=%0b d=%h rd=%0d err=%0b rdy=%0b exp 1 %h %0d %0b 1", n, v2, d, rrd, e, rdy3, exp_d, ins[26:24], ill);
      end
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(i[2:0], v, e);
      n_checks++; if (v !== m[i]) begin n_fail++; $display("FAIL rand_final_r%0d got %h exp %h", i, v, m[i]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_shift();
    test_stall();
    test_bypass();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
